// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: opcodes, instruction field positions, FSM states
// and flag bit indices shared by the execute stage.
package alu_exec_pkg;

  typedef enum logic [4:0] {
    OP_MOVSGPR = 5'd0,
    OP_MOV     = 5'd1,
    OP_ADD     = 5'd2,
    OP_SUB     = 5'd3,
    OP_MUL     = 5'd4,
    OP_OR      = 5'd5,
    OP_AND     = 5'd6,
    OP_XOR     = 5'd7,
    OP_XNOR    = 5'd8,
    OP_NAND    = 5'd9,
    OP_NOR     = 5'd10,
    OP_NOT     = 5'd11
  } oper_t;

  localparam int OP_LSB   = 27;
  localparam int RD_LSB   = 22;
  localparam int RS1_LSB  = 17;
  localparam int IMM_BIT  = 16;
  localparam int RS2_LSB  = 11;
  localparam int ISRC_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL
  } state_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  function automatic logic is_legal(input logic [4:0] op);
    return op <= OP_NOT;
  endfunction

endpackage

// File: rtl/alu_exec_unit_mul.sv
// alu_seq_mul: iterative unsigned shift-add multiplier, one bit/cycle.
// Ports: clk, rst, i_start/i_a/i_b in; o_busy, o_done pulse, o_product out.
module alu_seq_mul
  import alu_exec_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [DATA_W-1:0]     i_a,
  input  logic [DATA_W-1:0]     i_b,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [2*DATA_W-1:0]   o_product
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [CW-1:0]       r_cnt;
  logic [DATA_W-1:0]   r_mcand;
  logic [2*DATA_W-1:0] r_prod;
  logic                r_busy;
  logic                r_done;
  logic [DATA_W:0]     w_sum;

  // Upper half accumulates; low half holds the unconsumed multiplier bits.
  assign w_sum = {1'b0, r_prod[2*DATA_W-1:DATA_W]}
               + (r_prod[0] ? {1'b0, r_mcand} : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_mcand <= '0;
      r_prod  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_mcand <= i_a;
        r_prod  <= {{DATA_W{1'b0}}, i_b};
        r_cnt   <= '0;
        r_busy  <= 1'b1;
      end else if (r_busy) begin
        r_prod <= {w_sum, r_prod[DATA_W-1:1]};
        r_cnt  <= r_cnt + CW'(1);
        if (r_cnt == CW'(DATA_W - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_product = r_prod;

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multi-cycle execute stage owning GPRs and SGPR.
// Ports: in_valid/in_ready/in_instr handshake, done/err pulses,
// sgpr, flags {V,C,S,Z}, cfg_* GPR preload (IDLE only), dbg_* read.
// ALU_FLAGS_EN: compiles in the flag register; else flags = 0.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 32,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] sgpr,
  output logic [3:0]        flags,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] r_gpr [NUM_REGS];
  state_t            r_state;
  logic [4:0]        r_op;
  logic [ADDR_W-1:0] r_rdst;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_imm;
  logic [DATA_W-1:0] r_sgpr;
  logic              r_done;
  logic              r_err;

  logic [4:0]          w_op;
  logic                w_imm;
  logic [DATA_W-1:0]   w_isrc;
  logic [DATA_W-1:0]   w_rs1v;
  logic [DATA_W-1:0]   w_op2;
  logic                w_accept;
  logic                w_mul_start;
  logic                w_mul_busy;
  logic                w_mul_done;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_src;
  logic [DATA_W-1:0]   w_res;
  logic                w_illegal;
  logic                w_wr_exec;
  logic                w_wr_mul;
  logic                w_wr;

  assign w_op   = in_instr[OP_LSB +: 5];
  assign w_imm  = in_instr[IMM_BIT];
  assign w_isrc = DATA_W'(in_instr[ISRC_LSB +: 16]);
  assign w_rs1v = r_gpr[in_instr[RS1_LSB +: ADDR_W]];
  assign w_op2  = w_imm ? w_isrc : r_gpr[in_instr[RS2_LSB +: ADDR_W]];

  assign in_ready    = (r_state == S_IDLE) & ~w_mul_busy;
  assign w_accept    = in_valid & in_ready;
  assign w_mul_start = w_accept & (w_op == OP_MUL);

  alu_seq_mul #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk       (clk),
    .rst       (sys_rst),
    .i_start   (w_mul_start),
    .i_a       (w_rs1v),
    .i_b       (w_op2),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_prod)
  );

  // r_b already holds the immediate when imm_mode was set.
  assign w_src = r_imm ? r_b : r_a;

  always_comb begin
    w_res = '0;
    case (r_op)
      OP_MOVSGPR: w_res = r_sgpr;
      OP_MOV:     w_res = w_src;
      OP_ADD:     w_res = r_a + r_b;
      OP_SUB:     w_res = r_a - r_b;
      OP_MUL:     w_res = w_prod[DATA_W-1:0];
      OP_OR:      w_res = r_a | r_b;
      OP_AND:     w_res = r_a & r_b;
      OP_XOR:     w_res = r_a ^ r_b;
      OP_XNOR:    w_res = ~(r_a ^ r_b);
      OP_NAND:    w_res = ~(r_a & r_b);
      OP_NOR:     w_res = ~(r_a | r_b);
      OP_NOT:     w_res = ~w_src;
      default:    w_res = '0;
    endcase
  end

  assign w_illegal = ~is_legal(r_op);
  assign w_wr_exec = (r_state == S_EXEC) & ~w_illegal;
  assign w_wr_mul  = (r_state == S_MUL) & w_mul_done;
  assign w_wr      = w_wr_exec | w_wr_mul;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_rdst  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_imm   <= 1'b0;
      r_sgpr  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_gpr[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_wr) begin
        r_gpr[r_rdst] <= w_res;
      end
      if (w_wr_mul) begin
        r_sgpr <= w_prod[2*DATA_W-1:DATA_W];
      end
      case (r_state)
        S_IDLE: begin
          // Operands sampled from pre-edge GPRs, so a same-cycle
          // cfg write is invisible to the accepted instruction.
          if (cfg_we) begin
            r_gpr[cfg_addr] <= cfg_wdata;
          end
          if (w_accept) begin
            r_op    <= w_op;
            r_rdst  <= in_instr[RD_LSB +: ADDR_W];
            r_a     <= w_rs1v;
            r_b     <= w_op2;
            r_imm   <= w_imm;
            r_state <= (w_op == OP_MUL) ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          r_done  <= 1'b1;
          r_err   <= w_illegal;
          r_state <= S_IDLE;
        end
        S_MUL: begin
          if (w_mul_done) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_FLAGS_EN
  logic [3:0]      r_flags;
  logic [DATA_W:0] w_add_full;
  logic [DATA_W:0] w_sub_full;
  logic            w_a_msb;
  logic            w_b_msb;
  logic            w_r_msb;

  assign w_add_full = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub_full = {1'b0, r_a} - {1'b0, r_b};
  assign w_a_msb    = r_a[DATA_W-1];
  assign w_b_msb    = r_b[DATA_W-1];
  assign w_r_msb    = w_res[DATA_W-1];

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_flags <= '0;
    end else if (w_wr) begin
      r_flags[FLAG_Z] <= (w_res == '0);
      r_flags[FLAG_S] <= w_r_msb;
      case (r_op)
        OP_ADD: begin
          r_flags[FLAG_C] <= w_add_full[DATA_W];
          r_flags[FLAG_V] <= (w_a_msb == w_b_msb) & (w_r_msb != w_a_msb);
        end
        OP_SUB: begin
          // Top bit of the widened difference is the borrow.
          r_flags[FLAG_C] <= w_sub_full[DATA_W];
          r_flags[FLAG_V] <= (w_a_msb != w_b_msb) & (w_r_msb != w_a_msb);
        end
        OP_MUL: begin
          r_flags[FLAG_C] <= |w_prod[2*DATA_W-1:DATA_W];
          r_flags[FLAG_V] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign flags = r_flags;
`else
  assign flags = 4'b0000;
`endif

  assign done     = r_done;
  assign err      = r_err;
  assign sgpr     = r_sgpr;
  assign dbg_data = r_gpr[dbg_addr];

endmodule
